// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: size codes, FSM states, fault causes and access-legality helpers for the LSU
package riscv_lsu_pkg;
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;
  typedef enum logic [1:0] {IDLE, BUSY, FAULT} lsu_state_t;
  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_MISALIGN = 2'd1;
  localparam logic [1:0] FLT_SIZE     = 2'd2;
  localparam logic [1:0] FLT_BUS      = 2'd3;
  function automatic logic size_legal(input logic [2:0] s);
    return s inside {LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU};
  endfunction
  function automatic logic misaligned(input logic [2:0] s, input logic [1:0] a);
    return ((s == LDST_H || s == LDST_HU) && a[0]) || (s == LDST_W && a != 2'b00);
  endfunction
endpackage

// File: rtl/riscv_lsu_load_ext.sv
// riscv_lsu_load_ext: selects the load lane from a memory word and sign/zero extends it
module riscv_lsu_load_ext
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  // lane pick by byte offset, then extension by size code
  always_comb begin
    b = word_i[{off_i, 3'b000} +: 8];
    h = off_i[1] ? word_i[31:16] : word_i[15:0];
    data_o = size_i == LDST_B  ? {{24{b[7]}}, b} :
             size_i == LDST_BU ? {24'b0, b} :
             size_i == LDST_H  ? {{16{h[15]}}, h} :
             size_i == LDST_HU ? {16'b0, h} : word_i;
  end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: core data-port responder turning byte/half/word accesses into aligned memory transactions
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  lsu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d, wd_q, wd_d, ext;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d, cause_q, cause_d;
  logic        is_b, is_h;
  riscv_lsu_load_ext u_ext (
    .size_i (size_q),
    .off_i  (off_q),
    .word_i (mem_rd_i),
    .data_o (ext)
  );
  assign mem_req_o     = state_q == BUSY;
  assign mem_we_o      = we_q;
  assign mem_be_o      = be_q;
  assign mem_addr_o    = addr_q;
  assign mem_wd_o      = wd_q;
  assign fault_o       = state_q == FAULT;
  assign fault_cause_o = fault_o ? cause_q : FLT_NONE;
  // next-state, latching of the accepted access and core-facing outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    size_d       = size_q;
    off_d        = off_q;
    cause_d      = cause_q;
    core_stall_o = 1'b0;
    core_rd_o    = 32'b0;
    is_b         = core_size_i == LDST_B || core_size_i == LDST_BU;
    is_h         = core_size_i == LDST_H || core_size_i == LDST_HU;
    case (state_q)
      IDLE: if (core_req_i) begin
        core_stall_o = rst_i;
        if (!size_legal(core_size_i)) begin
          cause_d = FLT_SIZE;
          state_d = FAULT;
        end else if (misaligned(core_size_i, core_addr_i[1:0])) begin
          cause_d = FLT_MISALIGN;
          state_d = FAULT;
        end else begin
          we_d    = core_we_i;
          size_d  = core_size_i;
          off_d   = core_addr_i[1:0];
          addr_d  = {core_addr_i[31:2], 2'b00};
          be_d    = !core_we_i || core_size_i == LDST_W ? 4'b1111 :
                    is_h ? (core_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b0001 << core_addr_i[1:0];
          wd_d    = is_b ? {4{core_wd_i[7:0]}} : is_h ? {2{core_wd_i[15:0]}} : core_wd_i;
          state_d = BUSY;
        end
      end
      BUSY: begin
        core_stall_o = !mem_ready_i;
        if (mem_ready_i) begin
          core_rd_o = we_q ? 32'b0 : ext;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (cnt_q == LIMIT) begin
          cause_d = FLT_BUS;
          cnt_d   = '0;
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FAULT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and latched access registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0;
      addr_q  <= 32'b0;
      wd_q    <= 32'b0;
      size_q  <= 3'b0;
      off_q   <= 2'b0;
      cause_q <= FLT_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      size_q  <= size_d;
      off_q   <= off_d;
      cause_q <= cause_d;
    end
  end
endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit: the responder for the core's data-memory interface (req/we/size/addr/wd in; read data and stall back).
- Converts core byte/half/word accesses into aligned 32-bit memory transactions with byte enables.
- Holds the core stalled until the memory handshakes, and sign- or zero-extends load data.
- Flags misaligned accesses, illegal sizes and bus timeouts as faults for the trap logic.

Parameters:
- TIMEOUT_CYCLES, 16, BUSY cycles without mem_ready_i before the access is aborted (min 2).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- core_req_i  in  1  core requests a data access
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  LDST_B/H/W/BU/HU = 0/1/2/4/5
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, LSB-aligned
- core_rd_o  out  32  extended load data
- core_stall_o  out  1  hold core (PC enable = !stall)
- fault_o  out  1  one-cycle access fault pulse
- fault_cause_o  out  2  FLT_MISALIGN=1, FLT_SIZE=2, FLT_BUS=3
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wd_o  out  32  lane-replicated store data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  access complete, sampled only while mem_req_o=1

Behaviour:
- Reset values (async assert, deassert sync to clk_i): state IDLE, timeout counter 0, all registered mem_* outputs 0, fault_o=0, fault_cause_o=0, core_rd_o=0.
- FSM states: IDLE, BUSY, FAULT.
- IDLE, core_req_i=0: core_stall_o=0, mem_req_o=0.
- IDLE, core_req_i=1, legal and aligned: core_stall_o=1 (combinational). Latch we, be, aligned addr, replicated wd, size and addr[1:0]. Go to BUSY.
- IDLE, illegal size (3, 6, 7) or misaligned: core_stall_o=1. Latch cause; go to FAULT. No memory request is issued.
  - Misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=0. FLT_SIZE takes priority over FLT_MISALIGN.
- BUSY: mem_req_o=1 from registers; core_stall_o = !mem_ready_i.
  - On mem_ready_i=1: core_rd_o is valid in the same cycle (combinational from mem_rd_i plus latched size/offset). Next state IDLE. Minimum access latency is 2 cycles.
  - No ready: counter++. When counter reaches TIMEOUT_CYCLES-1 and mem_ready_i=0: set cause FLT_BUS, go to FAULT, deassert mem_req_o next cycle.
- FAULT (one cycle): core_stall_o=0, fault_o=1, fault_cause_o valid, core_rd_o=0. Next state IDLE.
- Store lanes:
  - B: be = 4'b0001 << addr[1:0], wd = {4{wd[7:0]}}.
  - H: be = 4'b0011 << {addr[1],1'b0}, wd = {2{wd[15:0]}}.
  - W: be = 4'b1111, wd unchanged.
- Loads drive mem_be_o = 4'b1111. The extract lane comes from the latched offset.
  - B/H are sign-extended; BU/HU are zero-extended.
  - core_rd_o = 0 whenever no load completes in the current cycle.
- Simultaneous events:
  - core_* changes during BUSY are ignored; the core holds its inputs while stalled.
  - mem_ready_i on the same cycle as the timeout limit: ready wins.
  - mem_ready_i outside BUSY is ignored.
- Back-to-back accesses: at least one IDLE cycle between accesses (the accept cycle).
- Reset mid-BUSY: immediate IDLE, mem_req_o=0. The memory must tolerate the abandoned request.

Decomposition:
- riscv_pkg additions:
  - LDST_B/H/W/BU/HU size codes.
  - lsu_state_t enum {IDLE, BUSY, FAULT}.
  - fault cause constants FLT_MISALIGN/FLT_SIZE/FLT_BUS.
- Sub-module riscv_lsu_load_ext: combinational lane select plus sign/zero extension (size, offset, word -> 32-bit result). Reused by the verification model.

Test Plan:
- SW addr=0x104, wd=0xDEADBEEF, ready on 2nd BUSY cycle -> mem_addr_o=0x104, be=1111, wd=0xDEADBEEF; stall high 2 cycles, then low.
- SB addr=0x203, wd=0x000000A5 -> mem_addr_o=0x200, be=1000, wd=0xA5A5A5A5.
- Load extension, all with mem_rd_i=0x80F1_7F82:
  - LB addr=0x301 -> core_rd_o=0x0000007F in the ready cycle.
  - LB addr=0x300 -> 0xFFFFFF82.
  - LHU addr=0x302 -> 0x000080F1.
  - LH addr=0x302 -> 0xFFFF80F1.
- LW addr=0x102 -> no mem_req_o. One stalled cycle, then fault_o=1, cause=1, stall=0.
- size=3 at addr=0x101 -> cause=2 (size priority over misalignment).
- TIMEOUT_CYCLES=4, mem_ready_i held 0 -> mem_req_o high 4 cycles, then fault_o with cause=3; stall released in the FAULT cycle.
- rst_i pulled low mid-BUSY -> mem_req_o=0 and core_stall_o=0 immediately. Next access after reset completes normally.
